// File: rtl/collision_response_unit_pkg.sv
// rtl/collision_response_unit_pkg.sv - shared game constants, state encoding and helpers
package collision_response_unit_pkg;

  localparam int LIVES_W      = 2;
  localparam int SEG_W        = 3;
  localparam int MAX_SEGMENTS = 7;
  localparam int INVULN_W     = 8;

  typedef enum logic [1:0] {
    ST_PLAY      = 2'd0,
    ST_GAME_OVER = 2'd1,
    ST_WIN       = 2'd2,
    ST_RESTART   = 2'd3
  } game_state_t;

  function automatic logic [MAX_SEGMENTS-1:0] seg_mask(input logic [SEG_W-1:0] n);
    logic [MAX_SEGMENTS-1:0] m;
    for (int i = 0; i < MAX_SEGMENTS; i++) m[i] = (SEG_W'(i) < n);
    return m;
  endfunction

endpackage

// File: rtl/collision_response_unit_if.sv
// rtl/collision_response_unit_if.sv - collision flags in, game status and event pulses out
interface collision_response_unit_if;
  import collision_response_unit_pkg::*;

  logic                    frame_end;
  logic                    playerDragonCollision;
  logic                    swordDragonCollision;
  logic                    sheepDragonCollision;
  logic                    start_btn;
  logic [LIVES_W-1:0]      player_lives;
  logic [SEG_W-1:0]        dragon_length;
  logic [MAX_SEGMENTS-1:0] active_segments;
  logic                    player_hit;
  logic                    dragon_hit;
  logic                    dragon_grow;
  logic                    invulnerable;
  logic [1:0]              game_state;

  modport master (
    output frame_end, playerDragonCollision, swordDragonCollision, sheepDragonCollision, start_btn,
    input  player_lives, dragon_length, active_segments, player_hit, dragon_hit, dragon_grow,
           invulnerable, game_state
  );

  modport slave (
    input  frame_end, playerDragonCollision, swordDragonCollision, sheepDragonCollision, start_btn,
    output player_lives, dragon_length, active_segments, player_hit, dragon_hit, dragon_grow,
           invulnerable, game_state
  );
endinterface

// File: rtl/collision_response_unit_sat_counter.sv
// rtl/collision_response_unit_sat_counter.sv - up/down counter saturating at 0 and MAX
module sat_counter #(
  parameter int           W       = 2,
  parameter logic [W-1:0] MAX     = '1,
  parameter logic [W-1:0] RST_VAL = '0
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         i_load,
  input  logic [W-1:0] i_load_val,
  input  logic         i_inc,
  input  logic         i_dec,
  output logic [W-1:0] o_count,
  output logic [W-1:0] o_next
);

  logic [W-1:0] r_count;
  logic [W-1:0] w_next;

  // Simultaneous inc and dec cancel; load wins over both.
  always_comb begin
    w_next = r_count;
    if (i_load)
      w_next = i_load_val;
    else if (i_inc && !i_dec && r_count != MAX)
      w_next = r_count + 1'b1;
    else if (i_dec && !i_inc && r_count != '0)
      w_next = r_count - 1'b1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_count <= RST_VAL;
    else        r_count <= w_next;
  end

  assign o_count = r_count;
  assign o_next  = w_next;

endmodule

// File: rtl/collision_response_unit.sv
// rtl/collision_response_unit.sv - per-frame collision resolution: lives, dragon length, game state
module collision_response_unit #(
  parameter int START_LIVES    = 3,
  parameter int INVULN_FRAMES  = 60,
  parameter int START_SEGMENTS = 1
) (
  input  logic                       clk,
  input  logic                       reset,
  collision_response_unit_if.slave   bus
);
  import collision_response_unit_pkg::*;

  game_state_t             r_state, w_state_next;
  logic                    w_sample, w_restart;
  logic                    w_player_hit, w_sword, w_sheep;
  logic                    w_inv_load;
  logic [INVULN_W-1:0]     w_inv_load_val;
  logic [LIVES_W-1:0]      w_lives, w_lives_next;
  logic [SEG_W-1:0]        w_len, w_len_next;
  logic [INVULN_W-1:0]     w_inv, w_inv_next;
  logic                    r_player_hit, r_dragon_hit, r_dragon_grow, r_invulnerable;
  logic [MAX_SEGMENTS-1:0] r_active;

  assign w_sample     = bus.frame_end && (r_state == ST_PLAY);
  assign w_restart    = (r_state == ST_RESTART);
  assign w_player_hit = w_sample && bus.playerDragonCollision && (w_inv == '0);
  assign w_sword      = w_sample && bus.swordDragonCollision;
  assign w_sheep      = w_sample && bus.sheepDragonCollision;

  assign w_inv_load     = w_restart || w_player_hit;
  assign w_inv_load_val = w_restart ? '0 : INVULN_W'(INVULN_FRAMES);

  sat_counter #(.W(LIVES_W), .MAX(LIVES_W'(START_LIVES)), .RST_VAL(LIVES_W'(START_LIVES))) u_lives (
    .clk(clk), .rst_n(reset), .i_load(w_restart), .i_load_val(LIVES_W'(START_LIVES)),
    .i_inc(1'b0), .i_dec(w_player_hit), .o_count(w_lives), .o_next(w_lives_next)
  );

  sat_counter #(.W(SEG_W), .MAX(SEG_W'(MAX_SEGMENTS)), .RST_VAL(SEG_W'(START_SEGMENTS))) u_length (
    .clk(clk), .rst_n(reset), .i_load(w_restart), .i_load_val(SEG_W'(START_SEGMENTS)),
    .i_inc(w_sheep), .i_dec(w_sword), .o_count(w_len), .o_next(w_len_next)
  );

  // A hit reloads the cooldown; every other sampled frame counts it down.
  sat_counter #(.W(INVULN_W), .MAX('1), .RST_VAL('0)) u_invuln (
    .clk(clk), .rst_n(reset), .i_load(w_inv_load), .i_load_val(w_inv_load_val),
    .i_inc(1'b0), .i_dec(w_sample), .o_count(w_inv), .o_next(w_inv_next)
  );

  always_comb begin
    w_state_next = r_state;
    case (r_state)
      ST_PLAY: begin
        if (w_player_hit && w_lives_next == '0)
          w_state_next = ST_GAME_OVER;
        else if (w_sample && w_len_next == '0)
          w_state_next = ST_WIN;
      end
      ST_GAME_OVER, ST_WIN: if (bus.start_btn) w_state_next = ST_RESTART;
      ST_RESTART:           w_state_next = ST_PLAY;
      default:              w_state_next = ST_PLAY;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) r_state <= ST_PLAY;
    else        r_state <= w_state_next;
  end

  // Decoded status is built from next-count values so it lines up with the counters.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_player_hit   <= 1'b0;
      r_dragon_hit   <= 1'b0;
      r_dragon_grow  <= 1'b0;
      r_invulnerable <= 1'b0;
      r_active       <= seg_mask(SEG_W'(START_SEGMENTS));
    end else begin
      r_player_hit   <= w_player_hit;
      r_dragon_hit   <= w_sword;
      r_dragon_grow  <= w_sheep;
      r_invulnerable <= (w_inv_next != '0);
      r_active       <= seg_mask(w_len_next);
    end
  end

  assign bus.player_lives    = w_lives;
  assign bus.dragon_length   = w_len;
  assign bus.active_segments = r_active;
  assign bus.player_hit      = r_player_hit;
  assign bus.dragon_hit      = r_dragon_hit;
  assign bus.dragon_grow     = r_dragon_grow;
  assign bus.invulnerable    = r_invulnerable;
  assign bus.game_state      = r_state;

endmodule

// File: tb/tb_collision_response_unit.sv
// tb/tb_collision_response_unit.sv - directed bench for collision_response_unit
module tb_collision_response_unit;

  logic clk = 1'b0;
  logic reset = 1'b0;
  int   checks = 0;
  int   errors = 0;

  always #5 clk = ~clk;

  collision_response_unit_if bus();

  collision_response_unit #(.START_LIVES(3), .INVULN_FRAMES(60), .START_SEGMENTS(1)) dut (
    .clk(clk), .reset(reset), .bus(bus)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic frame(input logic p, input logic s, input logic sh);
    @(negedge clk);
    bus.frame_end = 1'b1;
    bus.playerDragonCollision = p;
    bus.swordDragonCollision = s;
    bus.sheepDragonCollision = sh;
    @(negedge clk);
    bus.frame_end = 1'b0;
    bus.playerDragonCollision = 1'b0;
    bus.swordDragonCollision = 1'b0;
    bus.sheepDragonCollision = 1'b0;
  endtask

  task automatic idle_frames(input int n);
    for (int i = 0; i < n; i++) frame(1'b0, 1'b0, 1'b0);
  endtask

  task automatic do_restart(input logic fe_during_restart);
    @(negedge clk);
    bus.start_btn = 1'b1;
    @(negedge clk);
    bus.start_btn = 1'b0;
    chk("restart_state", 32'(bus.game_state), 32'd3);
    bus.frame_end = fe_during_restart;
    bus.playerDragonCollision = fe_during_restart;
    @(negedge clk);
    bus.frame_end = 1'b0;
    bus.playerDragonCollision = 1'b0;
    chk("restart_to_play", 32'(bus.game_state), 32'd0);
    chk("restart_lives", 32'(bus.player_lives), 32'd3);
    chk("restart_length", 32'(bus.dragon_length), 32'd1);
    chk("restart_invuln", 32'(bus.invulnerable), 32'd0);
    chk("restart_no_hit", 32'(bus.player_hit), 32'd0);
  endtask

  initial begin
    bus.frame_end = 1'b0;
    bus.playerDragonCollision = 1'b0;
    bus.swordDragonCollision = 1'b0;
    bus.sheepDragonCollision = 1'b0;
    bus.start_btn = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_state", 32'(bus.game_state), 32'd0);
    chk("rst_lives", 32'(bus.player_lives), 32'd3);
    chk("rst_length", 32'(bus.dragon_length), 32'd1);
    chk("rst_active", 32'(bus.active_segments), 32'h01);
    chk("rst_invuln", 32'(bus.invulnerable), 32'd0);
    chk("rst_pulses", {29'd0, bus.player_hit, bus.dragon_hit, bus.dragon_grow}, 32'd0);
    reset = 1'b1;

    frame(1'b1, 1'b0, 1'b0);
    chk("hit1_pulse", 32'(bus.player_hit), 32'd1);
    chk("hit1_lives", 32'(bus.player_lives), 32'd2);
    chk("hit1_invuln", 32'(bus.invulnerable), 32'd1);
    frame(1'b1, 1'b0, 1'b0);
    chk("invuln_hit_pulse", 32'(bus.player_hit), 32'd0);
    chk("invuln_hit_lives", 32'(bus.player_lives), 32'd2);
    idle_frames(58);
    chk("cooldown_59", 32'(bus.invulnerable), 32'd1);
    idle_frames(1);
    chk("cooldown_60", 32'(bus.invulnerable), 32'd0);

    @(negedge clk);
    bus.playerDragonCollision = 1'b1;
    bus.swordDragonCollision = 1'b1;
    bus.sheepDragonCollision = 1'b1;
    repeat (100) @(negedge clk);
    chk("nofe_lives", 32'(bus.player_lives), 32'd2);
    chk("nofe_length", 32'(bus.dragon_length), 32'd1);
    chk("nofe_pulses", {29'd0, bus.player_hit, bus.dragon_hit, bus.dragon_grow}, 32'd0);
    bus.playerDragonCollision = 1'b0;
    bus.swordDragonCollision = 1'b0;
    bus.sheepDragonCollision = 1'b0;

    frame(1'b1, 1'b0, 1'b0);
    chk("hit2_lives", 32'(bus.player_lives), 32'd1);

    for (int i = 0; i < 6; i++) frame(1'b0, 1'b0, 1'b1);
    chk("grow_len7", 32'(bus.dragon_length), 32'd7);
    chk("grow_active7", 32'(bus.active_segments), 32'h7f);
    frame(1'b0, 1'b0, 1'b1);
    chk("grow_sat_pulse", 32'(bus.dragon_grow), 32'd1);
    chk("grow_sat_len", 32'(bus.dragon_length), 32'd7);
    for (int i = 0; i < 3; i++) frame(1'b0, 1'b1, 1'b0);
    chk("shrink_len4", 32'(bus.dragon_length), 32'd4);
    chk("shrink_active4", 32'(bus.active_segments), 32'h0f);
    frame(1'b0, 1'b1, 1'b1);
    chk("both_len", 32'(bus.dragon_length), 32'd4);
    chk("both_pulses", {30'd0, bus.dragon_hit, bus.dragon_grow}, 32'd3);
    chk("mid_cooldown", 32'(bus.invulnerable), 32'd1);

    @(posedge clk);
    #3 reset = 1'b0;
    #1;
    chk("async_rst_lives", 32'(bus.player_lives), 32'd3);
    chk("async_rst_len", 32'(bus.dragon_length), 32'd1);
    chk("async_rst_invuln", 32'(bus.invulnerable), 32'd0);
    @(negedge clk);
    reset = 1'b1;

    frame(1'b1, 1'b0, 1'b0);
    chk("go_hit1", 32'(bus.player_lives), 32'd2);
    idle_frames(60);
    frame(1'b1, 1'b0, 1'b0);
    chk("go_hit2", 32'(bus.player_lives), 32'd1);
    idle_frames(60);
    frame(1'b1, 1'b0, 1'b0);
    chk("go_lives0", 32'(bus.player_lives), 32'd0);
    chk("go_state", 32'(bus.game_state), 32'd1);
    frame(1'b1, 1'b1, 1'b1);
    chk("go_no_pulses", {29'd0, bus.player_hit, bus.dragon_hit, bus.dragon_grow}, 32'd0);
    chk("go_hold_len", 32'(bus.dragon_length), 32'd1);
    chk("go_hold_state", 32'(bus.game_state), 32'd1);
    do_restart(1'b1);

    frame(1'b0, 1'b1, 1'b0);
    chk("win_len0", 32'(bus.dragon_length), 32'd0);
    chk("win_active0", 32'(bus.active_segments), 32'h00);
    chk("win_state", 32'(bus.game_state), 32'd2);
    chk("win_pulse", 32'(bus.dragon_hit), 32'd1);
    do_restart(1'b0);

    frame(1'b1, 1'b0, 1'b0);
    idle_frames(60);
    frame(1'b1, 1'b0, 1'b0);
    idle_frames(60);
    frame(1'b1, 1'b1, 1'b0);
    chk("prio_state", 32'(bus.game_state), 32'd1);
    chk("prio_lives", 32'(bus.player_lives), 32'd0);
    chk("prio_len", 32'(bus.dragon_length), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
